// File: rtl/uart_fifo_client_pkg.sv
// Shared definitions for the buffered uart client.
// Holds the uart byte width and the state encodings of the TX and RX
// handshake FSMs so the top level and any future siblings agree on them.
package uart_fifo_client_pkg;

    localparam int UART_DATA_W = 8;

    // TX side: pop a byte, pulse wr_en, then follow tx_busy high and low again.
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    // RX side: accept a byte, then spend one guard cycle while rdy drops.
    typedef enum logic {
        RX_IDLE,
        RX_ACK
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// The head entry is always presented on dout while the FIFO is not empty.
// A write becomes visible to the read side one cycle after it is pushed.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   wr, din       push request and data; a push on full is dropped
//   rd, dout      pop request and head data; a pop on empty is ignored
//   full, empty   occupancy flags
//   count         number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_wr;
    logic             do_rd;

    // Fullness is judged on the registered count, so a pop in the same cycle
    // never makes room for a push onto a full FIFO.
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/uart_fifo_client.sv
// Buffered host-side client of the uart byte interface.
// Outgoing bytes are queued in a TX FIFO and handed to the uart one at a time
// using the din/wr_en/tx_busy handshake. Received bytes are drained from the
// uart rdy/dout interface into an RX FIFO and acknowledged with rdy_clr.
// Ports:
//   clk_50m, rst            system clock, asynchronous active-high reset
//   tx_data, tx_wr          user byte to queue for transmission
//   tx_full, tx_idle        TX FIFO full; nothing queued, FSM idle, uart not busy
//   rx_data, rx_rd          show-ahead RX head and pop request
//   rx_empty                RX FIFO holds no bytes
//   rx_overrun, rx_ovr_clr  sticky dropped-byte flag and its clear
//   uart_din, uart_wr_en    byte and single-cycle write strobe to the uart
//   uart_tx_busy            uart transmitter busy
//   uart_rdy, uart_dout     received byte available and its value
//   uart_rdy_clr            single-cycle acknowledge of a received byte
module uart_fifo_client
    import uart_fifo_client_pkg::*;
#(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] tx_data,
    input  logic                   tx_wr,
    output logic                   tx_full,
    output logic                   tx_idle,
    output logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_rd,
    output logic                   rx_empty,
    output logic                   rx_overrun,
    input  logic                   rx_ovr_clr,
    output logic [UART_DATA_W-1:0] uart_din,
    output logic                   uart_wr_en,
    input  logic                   uart_tx_busy,
    input  logic                   uart_rdy,
    output logic                   uart_rdy_clr,
    input  logic [UART_DATA_W-1:0] uart_dout
);

    tx_state_t tx_state;
    tx_state_t tx_next;
    rx_state_t rx_state;
    rx_state_t rx_next;

    logic                         tx_pop;
    logic                         tx_empty;
    logic [UART_DATA_W-1:0]       tx_head;
    logic                         rx_push;
    logic                         rx_full;
    logic [$clog2(TX_DEPTH):0]    tx_count_unused;
    logic [$clog2(RX_DEPTH):0]    rx_count_unused;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk_50m),
        .rst   (rst),
        .wr    (tx_wr),
        .din   (tx_data),
        .rd    (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count_unused)
    );

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk_50m),
        .rst   (rst),
        .wr    (rx_push),
        .din   (uart_dout),
        .rd    (rx_rd),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count_unused)
    );

    assign tx_idle = tx_empty && (tx_state == TX_IDLE) && !uart_tx_busy;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // A byte is only launched from IDLE with tx_busy low, which also covers a
    // frame still on the line after reset; the uart cannot raise busy on its
    // own, so wr_en in ISSUE never coincides with busy.
    always_comb begin
        tx_next    = tx_state;
        tx_pop     = 1'b0;
        uart_wr_en = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (!tx_empty && !uart_tx_busy) begin
                    tx_pop  = 1'b1;
                    tx_next = TX_ISSUE;
                end
            end
            TX_ISSUE: begin
                uart_wr_en = 1'b1;
                tx_next    = TX_WAIT_BUSY;
            end
            TX_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    tx_next = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // The popped head is latched here and held until the next pop, keeping
    // din stable for the whole ISSUE..WAIT_DONE window.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            uart_din <= '0;
        end else if (tx_pop) begin
            uart_din <= tx_head;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // The byte is pushed in the same cycle it is acknowledged; the FIFO drops
    // it by itself when full. The ACK guard cycle lets the uart clear rdy
    // before it is looked at again.
    always_comb begin
        rx_next      = rx_state;
        rx_push      = 1'b0;
        uart_rdy_clr = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (uart_rdy) begin
                    rx_push      = 1'b1;
                    uart_rdy_clr = 1'b1;
                    rx_next      = RX_ACK;
                end
            end
            RX_ACK:  rx_next = RX_IDLE;
            default: rx_next = RX_IDLE;
        endcase
    end

    // Setting takes priority over clearing so a drop in the clear cycle is
    // never lost.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            rx_overrun <= 1'b0;
        end else if (rx_push && rx_full) begin
            rx_overrun <= 1'b1;
        end else if (rx_ovr_clr) begin
            rx_overrun <= 1'b0;
        end
    end

endmodule
